uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
Downstream stage of the message generator. It accepts one byte per strobe/busy handshake and shifts it out on a single UART TX line as 8N1, LSB first. The bit period is a fixed number of clocks, set by parameter. It is the block the top-level hello-world sequencer drives with its strobe, data and busy signals.

Parameters:
CLOCKS_PER_BAUD, 24'd868, clocks per bit (100 MHz / 115200); 24-bit; legal range 2..2^24-1
DATA_BITS, 8, fixed at 8; any other value is illegal and checked at elaboration

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_wr  input  1  byte request (strobe); accepted when i_wr && !o_busy
i_data  input  8  byte to send; sampled only at accept
o_uart_tx  output  1  serial line; idles high
o_busy  output  1  high while a frame is in flight; requester holds i_wr/i_data until it sees !o_busy

Behaviour:
- Reset (i_reset_n low, async): o_uart_tx=1, o_busy=0, state=IDLE, baud counter=0, bit index=0, shift reg=8'hFF. Takes effect immediately, including mid-frame. The line returns high with no partial stop bit.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, STOP (+PARITY, optional).
- IDLE: o_uart_tx=1, o_busy=0. On i_wr at edge k: latch i_data into shift reg, load baud counter=CLOCKS_PER_BAUD-1, go to START. From edge k: o_busy=1 and o_uart_tx=0.
- Baud counter counts down each clock. A bit ends when the counter is 0; the counter then reloads CLOCKS_PER_BAUD-1. Each bit is exactly CLOCKS_PER_BAUD cycles.
- START -> DATA. DATA sends shift reg[0] and shifts right (fills with 1). After bit index 7 -> STOP. STOP drives 1.
- End of STOP -> IDLE, o_busy=0. o_busy is therefore high for exactly 10*CLOCKS_PER_BAUD cycles per frame.
- i_wr held high continuously: the next frame is accepted on the first cycle o_busy=0. The frame period is 10*CLOCKS_PER_BAUD+1 cycles (stop bit stretched by one clock).
- i_wr while o_busy: ignored, no state change. i_data changes during a frame have no effect on the line.
- Counter width is 24 bits. No wrap-around occurs within legal parameter range.
- Formal properties:
  - o_busy==0 iff state==IDLE.
  - In IDLE, o_uart_tx==1.
  - baud counter < CLOCKS_PER_BAUD.
  - bit index <= 7.
  - $stable(shift reg) unless (accept || bit end in DATA).

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It sends even parity (XOR of the 8 latched data bits) for one bit period. o_busy is high for 11*CLOCKS_PER_BAUD cycles; back-to-back period is 11*CLOCKS_PER_BAUD+1.
- Undefined: no PARITY state; plain 8N1 as above.

Test Plan:
- Reset idle, CPB=4: hold i_reset_n=0 then release, no i_wr for 100 cycles -> o_uart_tx=1, o_busy=0 throughout.
- Single byte, CPB=4: i_wr=1 one cycle, i_data=8'h48 -> line samples every 4 cycles read 0 (start), then 0,0,0,1,0,0,1,0, then 1 (stop). o_busy high exactly 40 cycles.
- Back-to-back, CPB=4: i_wr held high with "H" then "e" (8'h65) -> second start bit begins 41 cycles after the first. Data bits for 8'h65 read 1,0,1,0,0,1,1,0.
- Ignored write, CPB=4: i_wr=1 with 8'hFF pulsed during the DATA bits of an 8'h00 frame -> line still sends eight 0 data bits; o_busy unchanged; no extra frame.
- Reset mid-frame, CPB=4: assert i_reset_n=0 at cycle 17 of an 8'h00 frame -> o_uart_tx=1 and o_busy=0 in the same cycle. After release, a new i_wr with 8'h55 sends a clean frame.
- Parity (UART_TX_PARITY_EN), CPB=4: 8'h07 -> parity bit=1 and o_busy high for 44 cycles; 8'h03 -> parity bit=0.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 LSB-first UART transmitter with strobe/busy handshake; define UART_TX_PARITY_EN to add an even-parity bit
module uart_tx_serializer #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868,
    parameter int          DATA_BITS       = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_uart_tx,
    output logic       o_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t      state, state_d;
    logic [23:0] cnt, cnt_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  sh, sh_d;
    logic        tx_d, bit_end;
`ifdef UART_TX_PARITY_EN
    logic        par, par_d;
`endif
    if (DATA_BITS != 8 || CLOCKS_PER_BAUD < 24'd2) begin : g_bad_param
        $error("uart_tx_serializer: DATA_BITS must be 8 and CLOCKS_PER_BAUD must be >= 2");
    end
    assign bit_end = cnt == 24'd0;
    always_comb begin
        state_d = state;
        cnt_d   = state == IDLE ? cnt : (bit_end ? CLOCKS_PER_BAUD - 24'd1 : cnt - 24'd1);
        idx_d   = idx;
        sh_d    = sh;
        tx_d    = o_uart_tx;
`ifdef UART_TX_PARITY_EN
        par_d   = par;
`endif
        case (state)
            IDLE: if (i_wr) begin
                state_d = START;
                sh_d    = i_data;
                cnt_d   = CLOCKS_PER_BAUD - 24'd1;
                tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                par_d   = ^i_data;
`endif
            end
            START: if (bit_end) begin
                state_d = DATA;
                tx_d    = sh[0];
            end
            DATA: if (bit_end) begin
                sh_d  = {1'b1, sh[7:1]};
                idx_d = idx + 3'd1;
                tx_d  = sh[1];
                if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (bit_end) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= 8'hFF;
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            sh        <= sh_d;
            o_uart_tx <= tx_d;
            o_busy    <= state_d != IDLE;
`ifdef UART_TX_PARITY_EN
            par       <= par_d;
`endif
        end
    end
endmodule
